// File: rtl/carfield_region_map_pkg.sv
// Shared types and helpers for the runtime-programmable carfield address map.
package carfield_region_map_pkg;

    // Width of the base and size fields stored in every map entry.
    localparam int unsigned RegionAddrWidth = 64;

    typedef struct packed {
        logic                       en;
        logic [RegionAddrWidth-1:0] base;
        logic [RegionAddrWidth-1:0] size;
    } region_t;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StResp
    } cfg_state_e;

    // Exclusive end address, one bit wider so base+size never wraps.
    function automatic logic [RegionAddrWidth:0] region_end(input region_t r);
        return {1'b0, r.base} + {1'b0, r.size};
    endfunction

    // A zero size disables an entry even when en is set.
    function automatic logic region_active(input region_t r);
        return r.en && (r.size != '0);
    endfunction

    // The entry ends at or below the top of the address space.
    function automatic logic region_fits(input region_t r);
        logic [RegionAddrWidth:0] limit;
        limit                  = '0;
        limit[RegionAddrWidth] = 1'b1;
        return region_end(r) <= limit;
    endfunction

    function automatic logic region_overlap(input region_t a, input region_t b);
        return region_active(a) && region_active(b)
            && ({1'b0, a.base} < region_end(b))
            && ({1'b0, b.base} < region_end(a));
    endfunction

    function automatic logic region_match(input region_t r, input logic [RegionAddrWidth-1:0] addr);
        return region_active(r) && (addr >= r.base) && ({1'b0, addr} < region_end(r));
    endfunction

    // Default carfield map: periph, ethernet, safety island (size 0, disabled),
    // mailbox, PULP cluster, Spatz cluster, L2 port 0, L2 port 1.
    localparam region_t [7:0] CarfieldResetMap = {
        region_t'{en: 1'b1, base: 64'h0000_0000_7820_0000, size: 64'h0000_0000_0020_0000},
        region_t'{en: 1'b1, base: 64'h0000_0000_7800_0000, size: 64'h0000_0000_0020_0000},
        region_t'{en: 1'b1, base: 64'h0000_0000_5100_0000, size: 64'h0000_0000_0080_0000},
        region_t'{en: 1'b1, base: 64'h0000_0000_5000_0000, size: 64'h0000_0000_0080_0000},
        region_t'{en: 1'b1, base: 64'h0000_0000_4000_0000, size: 64'h0000_0000_0000_1000},
        region_t'{en: 1'b1, base: 64'h0000_0000_2200_0000, size: 64'h0000_0000_0000_0000},
        region_t'{en: 1'b1, base: 64'h0000_0000_2010_0000, size: 64'h0000_0000_0001_0000},
        region_t'{en: 1'b1, base: 64'h0000_0000_2000_0000, size: 64'h0000_0000_0001_0000}
    };

endpackage

// File: rtl/carfield_region_lookup.sv
// Priority address decode against the committed map with a registered response.
module carfield_region_lookup
    import carfield_region_map_pkg::*;
#(
    parameter int unsigned NumRegions = 8,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdxWidth   = $clog2(NumRegions)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  region_t [NumRegions-1:0]       regions_i,
    input  logic                           lkp_valid_i,
    input  logic [AddrWidth-1:0]           lkp_addr_i,
    output logic                           lkp_valid_o,
    output logic                           lkp_hit_o,
    output logic [IdxWidth-1:0]            lkp_idx_o
);

    logic                valid_q, valid_d;
    logic                hit_q, hit_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic                match_hit;
    logic [IdxWidth-1:0] match_idx;

    // Lowest matching index wins; outputs hold when no lookup is presented.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < NumRegions; i++) begin
            if (!match_hit && region_match(regions_i[i], RegionAddrWidth'(lkp_addr_i))) begin
                match_hit = 1'b1;
                match_idx = IdxWidth'(i);
            end
        end
        valid_d = lkp_valid_i;
        hit_d   = lkp_valid_i ? match_hit : hit_q;
        idx_d   = lkp_valid_i ? match_idx : idx_q;
    end

    // Response register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    assign lkp_valid_o = valid_q;
    assign lkp_hit_o   = hit_q;
    assign lkp_idx_o   = idx_q;

endmodule

// File: rtl/carfield_region_map.sv
// Runtime-programmable address map: validated config updates and pipelined lookups.
// AddrWidth must equal the package region field width.
module carfield_region_map
    import carfield_region_map_pkg::*;
#(
    parameter int unsigned             NumRegions = 8,
    parameter int unsigned             AddrWidth  = 64,
    parameter region_t [NumRegions-1:0] ResetMap  = '0,
    localparam int unsigned            IdxWidth   = $clog2(NumRegions)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic                 cfg_en_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_size_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_rsp_valid_o,
    output logic                 cfg_rsp_err_o,
    output logic                 locked_o,
    input  logic                 lkp_valid_i,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    output logic                 lkp_valid_o,
    output logic                 lkp_hit_o,
    output logic [IdxWidth-1:0]  lkp_idx_o
);

    cfg_state_e               state_q, state_d;
    region_t [NumRegions-1:0] map_q, map_d;
    region_t                  stage_q, stage_d;
    logic [IdxWidth-1:0]      stage_idx_q, stage_idx_d;
    logic                     stage_lock_q, stage_lock_d;
    logic [IdxWidth-1:0]      cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     locked_q, locked_d;
    region_t                  req;

    assign req = '{en: cfg_en_i, base: cfg_base_i, size: cfg_size_i};

    // Config FSM: stage request, scan the map one entry per cycle, respond and commit.
    always_comb begin
        state_d      = state_q;
        map_d        = map_q;
        stage_d      = stage_q;
        stage_idx_d  = stage_idx_q;
        stage_lock_d = stage_lock_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        locked_d     = locked_q;
        case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    stage_d      = req;
                    stage_idx_d  = cfg_idx_i;
                    stage_lock_d = cfg_lock_i;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    if (locked_q || !region_fits(req)) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (!region_active(req)) begin
                        state_d = StResp;
                    end else begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if ((cnt_q != stage_idx_q) && region_overlap(stage_q, map_q[cnt_q])) begin
                    err_d = 1'b1;
                end
                if (cnt_q == IdxWidth'(NumRegions - 1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + IdxWidth'(1);
                end
            end
            StResp: begin
                if (!err_q) begin
                    if (32'(stage_idx_q) < NumRegions) begin
                        map_d[stage_idx_q] = stage_q;
                    end
                    if (stage_lock_q) begin
                        locked_d = 1'b1;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, staging and committed map registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            map_q        <= ResetMap;
            stage_q      <= '0;
            stage_idx_q  <= '0;
            stage_lock_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            map_q        <= map_d;
            stage_q      <= stage_d;
            stage_idx_q  <= stage_idx_d;
            stage_lock_q <= stage_lock_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
        end
    end

    assign cfg_ready_o     = (state_q == StIdle);
    assign cfg_rsp_valid_o = (state_q == StResp);
    assign cfg_rsp_err_o   = (state_q == StResp) && err_q;
    assign locked_o        = locked_q;

    carfield_region_lookup #(
        .NumRegions (NumRegions),
        .AddrWidth  (AddrWidth),
        .IdxWidth   (IdxWidth)
    ) u_lookup (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .regions_i   (map_q),
        .lkp_valid_i (lkp_valid_i),
        .lkp_addr_i  (lkp_addr_i),
        .lkp_valid_o (lkp_valid_o),
        .lkp_hit_o   (lkp_hit_o),
        .lkp_idx_o   (lkp_idx_o)
    );

endmodule

// File: tb/tb_carfield_region_map.sv
// Bench for carfield_region_map: randomized config/lookup traffic against a behavioural map model.
module tb_carfield_region_map;
    import carfield_region_map_pkg::*;

    localparam int NREG = 8;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [2:0]  cfg_idx_i = '0;
    logic        cfg_en_i = 1'b0;
    logic [63:0] cfg_base_i = '0;
    logic [63:0] cfg_size_i = '0;
    logic        cfg_lock_i = 1'b0;
    logic        cfg_rsp_valid_o;
    logic        cfg_rsp_err_o;
    logic        locked_o;
    logic        lkp_valid_i = 1'b0;
    logic [63:0] lkp_addr_i = '0;
    logic        lkp_valid_o;
    logic        lkp_hit_o;
    logic [2:0]  lkp_idx_o;

    int checks   = 0;
    int failures = 0;

    carfield_region_map #(
        .NumRegions (NREG),
        .AddrWidth  (64),
        .ResetMap   (CarfieldResetMap)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_idx_i       (cfg_idx_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_base_i      (cfg_base_i),
        .cfg_size_i      (cfg_size_i),
        .cfg_lock_i      (cfg_lock_i),
        .cfg_rsp_valid_o (cfg_rsp_valid_o),
        .cfg_rsp_err_o   (cfg_rsp_err_o),
        .locked_o        (locked_o),
        .lkp_valid_i     (lkp_valid_i),
        .lkp_addr_i      (lkp_addr_i),
        .lkp_valid_o     (lkp_valid_o),
        .lkp_hit_o       (lkp_hit_o),
        .lkp_idx_o       (lkp_idx_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_en   [NREG];
    logic [63:0] m_base [NREG];
    logic [63:0] m_size [NREG];
    bit          m_locked;

    function automatic void m_reset();
        logic [63:0] b [NREG];
        logic [63:0] s [NREG];
        b = '{64'h2000_0000, 64'h2010_0000, 64'h2200_0000, 64'h4000_0000,
              64'h5000_0000, 64'h5100_0000, 64'h7800_0000, 64'h7820_0000};
        s = '{64'h1_0000, 64'h1_0000, 64'h0, 64'h1000,
              64'h80_0000, 64'h80_0000, 64'h20_0000, 64'h20_0000};
        for (int i = 0; i < NREG; i++) begin
            m_en[i]   = 1'b1;
            m_base[i] = b[i];
            m_size[i] = s[i];
        end
        m_locked = 1'b0;
    endfunction

    function automatic bit m_active(input int i);
        return m_en[i] && (m_size[i] != 64'd0);
    endfunction

    function automatic void m_lookup(input logic [63:0] a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NREG; i++) begin
            if (!hit && m_active(i) && a >= m_base[i] && 65'(a) < 65'(m_base[i]) + 65'(m_size[i])) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    function automatic void m_predict(input int idx, input bit en, input logic [63:0] base,
                                      input logic [63:0] size, output bit err, output int lat);
        logic [64:0] s_end;
        s_end = 65'(base) + 65'(size);
        err = 1'b0;
        if (m_locked || s_end > {1'b1, 64'd0}) begin
            err = 1'b1;
            lat = 1;
        end else if (!(en && size != 64'd0)) begin
            lat = 1;
        end else begin
            lat = NREG + 1;
            for (int j = 0; j < NREG; j++) begin
                if (j != idx && m_active(j) && 65'(base) < 65'(m_base[j]) + 65'(m_size[j])
                    && 65'(m_base[j]) < s_end)
                    err = 1'b1;
            end
        end
    endfunction

    function automatic void m_commit(input int idx, input bit en, input logic [63:0] base,
                                     input logic [63:0] size, input bit lock);
        m_en[idx]   = en;
        m_base[idx] = base;
        m_size[idx] = size;
        if (lock) m_locked = 1'b1;
    endfunction

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic do_lookup(input logic [63:0] a, output bit vld, output bit hit, output int idx);
        lkp_valid_i = 1'b1;
        lkp_addr_i  = a;
        @(negedge clk);
        vld = lkp_valid_o;
        hit = lkp_hit_o;
        idx = int'(lkp_idx_o);
        lkp_valid_i = 1'b0;
    endtask

    task automatic do_cfg(input int idx, input bit en, input logic [63:0] base, input logic [63:0] size,
                          input bit lock, output bit err, output int lat);
        cfg_valid_i = 1'b1;
        cfg_idx_i   = 3'(idx);
        cfg_en_i    = en;
        cfg_base_i  = base;
        cfg_size_i  = size;
        cfg_lock_i  = lock;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        lat = -1;
        err = 1'b0;
        for (int k = 1; k <= 4 * NREG; k++) begin
            if (k > 1) @(negedge clk);
            if (cfg_rsp_valid_o) begin
                lat = k;
                err = cfg_rsp_err_o;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    // Write, then look up in the RESP cycle (old map) and the cycle after (new map).
    task automatic cfg_and_probe(input string name, input int idx, input bit en, input logic [63:0] base,
                                 input logic [63:0] size, input bit lock, input logic [63:0] probe);
        bit e_err, g_err, vld, hit, e_hit;
        int e_lat, g_lat, i_g, i_e;
        m_predict(idx, en, base, size, e_err, e_lat);
        do_cfg(idx, en, base, size, lock, g_err, g_lat);
        checks++;
        if (g_lat !== e_lat || g_err !== e_err) begin
            failures++;
            $display("FAIL %s rsp: lat=%0d err=%0b expected lat=%0d err=%0b", name, g_lat, g_err, e_lat, e_err);
        end
        m_lookup(probe, e_hit, i_e);
        do_lookup(probe, vld, hit, i_g);
        checks++;
        if (vld !== 1'b1 || hit !== e_hit || i_g !== i_e) begin
            failures++;
            $display("FAIL %s old_map_lkp %0h: vld=%0b hit=%0b idx=%0d expected 1/%0b/%0d", name, probe, vld, hit, i_g, e_hit, i_e);
        end
        if (!e_err) m_commit(idx, en, base, size, lock);
        m_lookup(probe, e_hit, i_e);
        do_lookup(probe, vld, hit, i_g);
        checks++;
        if (vld !== 1'b1 || hit !== e_hit || i_g !== i_e) begin
            failures++;
            $display("FAIL %s new_map_lkp %0h: vld=%0b hit=%0b idx=%0d expected 1/%0b/%0d", name, probe, vld, hit, i_g, e_hit, i_e);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit vld, hit;
        int idx;
        @(negedge clk);
        checks++;
        if ({cfg_ready_o, cfg_rsp_valid_o, cfg_rsp_err_o, locked_o, lkp_valid_o, lkp_hit_o, lkp_idx_o} !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%0b rv=%0b re=%0b lk=%0b lv=%0b hit=%0b idx=%0d expected 1/0/0/0/0/0/0",
                     cfg_ready_o, cfg_rsp_valid_o, cfg_rsp_err_o, locked_o, lkp_valid_o, lkp_hit_o, lkp_idx_o);
        end
        rst_ni = 1'b1;
        m_reset();
        @(negedge clk);
        do_lookup(64'h7801_0000, vld, hit, idx);
        checks++;
        if (vld !== 1'b1 || hit !== 1'b1 || idx !== 6) begin
            failures++;
            $display("FAIL reset_lkp_l2 got vld=%0b hit=%0b idx=%0d expected 1/1/6", vld, hit, idx);
        end
        do_lookup(64'h7000_0000, vld, hit, idx);
        checks++;
        if (vld !== 1'b1 || hit !== 1'b0 || idx !== 0) begin
            failures++;
            $display("FAIL reset_lkp_miss got vld=%0b hit=%0b idx=%0d expected 1/0/0", vld, hit, idx);
        end
        do_lookup(64'h2200_0000, vld, hit, idx);
        checks++;
        if (hit !== 1'b0 || idx !== 0) begin
            failures++;
            $display("FAIL reset_lkp_zero_size got hit=%0b idx=%0d expected 0/0", hit, idx);
        end
    endtask

    task automatic test_directed();
        cfg_and_probe("write_ok",      2, 1'b1, 64'h3000_0000, 64'h1000, 1'b0, 64'h3000_0800);
        cfg_and_probe("write_overlap", 3, 1'b1, 64'h7801_0000, 64'h1000, 1'b0, 64'h7801_0000);
        cfg_and_probe("write_ovf",     4, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 1'b0, 64'hFFFF_FFFF_FFFF_F800);
        cfg_and_probe("write_top_end", 5, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_and_probe("write_disable", 6, 1'b0, 64'h7800_0000, 64'h20_0000, 1'b0, 64'h7801_0000);
        cfg_and_probe("write_self",    7, 1'b1, 64'h7820_1000, 64'h1000, 1'b0, 64'h7820_1000);
    endtask

    task automatic test_back_to_back();
        bit vld, hit, e_hit, prev_v;
        int idx, e_idx;
        logic [63:0] prev_a;
        do_lookup(64'h2000_0000, vld, hit, idx);
        m_lookup(64'h2000_0000, e_hit, e_idx);
        prev_v = 1'b0;
        prev_a = '0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                if (prev_v) m_lookup(prev_a, e_hit, e_idx);
                checks++;
                if (lkp_valid_o !== prev_v || lkp_hit_o !== e_hit || int'(lkp_idx_o) !== e_idx) begin
                    failures++;
                    $display("FAIL stream_lkp cyc%0d got vld=%0b hit=%0b idx=%0d expected %0b/%0b/%0d",
                             c, lkp_valid_o, lkp_hit_o, lkp_idx_o, prev_v, e_hit, e_idx);
                end
            end
            prev_v = ($urandom_range(0, 3) != 0);
            prev_a = (m_base[$urandom_range(0, NREG - 1)]) + 64'($urandom_range(0, 32'h20_0000)) - 64'h1000;
            lkp_valid_i = prev_v;
            lkp_addr_i  = prev_a;
            @(negedge clk);
        end
        lkp_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int idx, j, sel;
        bit en;
        logic [63:0] base, size, probe;
        for (int t = 0; t < 30; t++) begin
            idx = $urandom_range(0, NREG - 1);
            en  = ($urandom_range(0, 9) != 0);
            base = 64'h6000_0000 + (64'($urandom_range(0, 63)) << 16);
            case ($urandom_range(0, 4))
                0: size = 64'd0;
                1: size = 64'h1000;
                2: size = 64'h1_0000;
                3: size = 64'h10_0000;
                default: begin
                    base = 64'hFFFF_FFFF_FFFF_0000;
                    size = 64'($urandom_range(1, 3)) << 15;
                end
            endcase
            j   = $urandom_range(0, NREG - 1);
            sel = $urandom_range(0, 3);
            probe = (sel == 0) ? base : (sel == 1) ? base + size - 64'd1 :
                    (sel == 2) ? base + size : m_base[j] - 64'd1;
            cfg_and_probe("rand_write", idx, en, base, size, 1'b0, probe);
        end
    endtask

    task automatic test_busy_ignored();
        bit e_err, e_hit, vld, hit;
        int e_lat, g_lat, extra, i_g, i_e;
        m_predict(2, 1'b1, 64'h3400_0000, 64'h100, e_err, e_lat);
        cfg_valid_i = 1'b1;
        cfg_idx_i   = 3'd2;
        cfg_en_i    = 1'b1;
        cfg_base_i  = 64'h3400_0000;
        cfg_size_i  = 64'h100;
        cfg_lock_i  = 1'b0;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        g_lat = -1;
        for (int k = 1; k <= 4 * NREG; k++) begin
            if (k > 1) @(negedge clk);
            if (cfg_rsp_valid_o) begin
                g_lat = k;
                break;
            end
            if (k == 2) begin
                cfg_valid_i = 1'b1;
                cfg_idx_i   = 3'd0;
                cfg_base_i  = 64'h7000_0000;
                cfg_size_i  = 64'h1000;
            end else begin
                cfg_valid_i = 1'b0;
            end
        end
        cfg_valid_i = 1'b0;
        checks++;
        if (g_lat !== e_lat) begin
            failures++;
            $display("FAIL busy_latency got %0d expected %0d", g_lat, e_lat);
        end
        if (!e_err) m_commit(2, 1'b1, 64'h3400_0000, 64'h100, 1'b0);
        extra = 0;
        for (int k = 0; k < NREG + 3; k++) begin
            @(negedge clk);
            if (cfg_rsp_valid_o) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL busy_queued got %0d extra responses expected 0", extra);
        end
        m_lookup(64'h7000_0000, e_hit, i_e);
        do_lookup(64'h7000_0000, vld, hit, i_g);
        checks++;
        if (hit !== e_hit || i_g !== i_e) begin
            failures++;
            $display("FAIL busy_table got hit=%0b idx=%0d expected %0b/%0d", hit, i_g, e_hit, i_e);
        end
    endtask

    task automatic test_lock();
        bit vld, hit;
        int idx;
        apply_reset();
        cfg_and_probe("lock_write", 2, 1'b1, 64'h3100_0000, 64'h1000, 1'b1, 64'h3100_0000);
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL locked_set got %0b expected 1", locked_o);
        end
        cfg_and_probe("locked_write", 2, 1'b1, 64'h3200_0000, 64'h1000, 1'b0, 64'h3200_0000);
        do_lookup(64'h3100_0800, vld, hit, idx);
        checks++;
        if (hit !== 1'b1 || idx !== 2) begin
            failures++;
            $display("FAIL locked_unchanged got hit=%0b idx=%0d expected 1/2", hit, idx);
        end
        cfg_and_probe("locked_inactive", 3, 1'b0, 64'h0, 64'h0, 1'b0, 64'h4000_0000);
        apply_reset();
        checks++;
        if (locked_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_after_reset got %0b expected 0", locked_o);
        end
    endtask

    task automatic test_reset_mid_check();
        bit vld, hit, e_hit;
        int idx, e_idx, pulses;
        cfg_valid_i = 1'b1;
        cfg_idx_i   = 3'd2;
        cfg_en_i    = 1'b1;
        cfg_base_i  = 64'h3000_0000;
        cfg_size_i  = 64'h1000;
        cfg_lock_i  = 1'b1;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL midcheck_busy got ready=%0b expected 0", cfg_ready_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1 || cfg_rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midcheck_async got ready=%0b rv=%0b expected 1/0", cfg_ready_o, cfg_rsp_valid_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        m_reset();
        pulses = 0;
        for (int k = 0; k < 2 * NREG; k++) begin
            @(negedge clk);
            if (cfg_rsp_valid_o) pulses++;
        end
        checks++;
        if (pulses !== 0 || locked_o !== 1'b0) begin
            failures++;
            $display("FAIL midcheck_no_rsp got pulses=%0d locked=%0b expected 0/0", pulses, locked_o);
        end
        for (int i = 0; i < NREG; i++) begin
            m_lookup(m_base[i], e_hit, e_idx);
            do_lookup(m_base[i], vld, hit, idx);
            checks++;
            if (hit !== e_hit || idx !== e_idx) begin
                failures++;
                $display("FAIL midcheck_map[%0d] got hit=%0b idx=%0d expected %0b/%0d", i, hit, idx, e_hit, e_idx);
            end
        end
        do_lookup(64'h3000_0800, vld, hit, idx);
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL midcheck_staged_visible got hit=%0b idx=%0d expected 0", hit, idx);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_busy_ignored();
        test_lock();
        test_reset_mid_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carfield_region_map.md
# carfield_region_map

Runtime-programmable successor to the static carfield address-map configuration. It holds `NumRegions` base/size/enable entries and initialises them from a reset map. It accepts validated updates over a config handshake, with a sequential overlap check and a sticky lock, and answers pipelined address lookups with the matching region index. It sits between the platform control registers and the host crossbar decode logic.

## Interface
- `NumRegions`, 8: number of map entries; must be ≥ 2.
- `AddrWidth`, 64: address, base and size width (matches `doub_bt`).
- `ResetMap`, all-zero: per-entry reset {en, base, size}; the default build passes the carfield L2/Ethernet/periph/cluster/mailbox map.
- `IdxWidth`, `$clog2(NumRegions)`: derived, not overridable.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `cfg_valid_i` in 1: update request.
- `cfg_ready_o` out 1: high only in IDLE.
- `cfg_idx_i` in IdxWidth: entry to replace.
- `cfg_en_i` in 1: new enable.
- `cfg_base_i` in AddrWidth: new base.
- `cfg_size_i` in AddrWidth: new size.
- `cfg_lock_i` in 1: lock the table after a successful commit.
- `cfg_rsp_valid_o` out 1: one-cycle completion pulse.
- `cfg_rsp_err_o` out 1: rejected; qualified by `cfg_rsp_valid_o`.
- `locked_o` out 1: table locked.
- `lkp_valid_i` in 1: lookup request; always accepted.
- `lkp_addr_i` in AddrWidth: address to decode.
- `lkp_valid_o` out 1: registered lookup response.
- `lkp_hit_o` out 1: address fell in an enabled region.
- `lkp_idx_o` out IdxWidth: matching region; 0 when there is no hit.

## Operation
- Entry `i` is active when `en`=1 and `size` != 0. A zero size means the entry is disabled even with `en`=1, as for the security-island entry.
- Match rule: `base <= addr < base+size`.
  - Evaluate the sum at AddrWidth+1 bits so there is no wrap.
  - On multiple matches, the lowest index wins.
- FSM states are IDLE, CHECK and RESP.
- IDLE: the handshake `cfg_valid_i & cfg_ready_o` latches the request into a staging register.
  - If `locked_q`=1, reject and go to RESP.
  - If base+size > 2^AddrWidth, reject and go to RESP.
  - If the staged entry is inactive, go straight to RESP as a success; no check is needed.
  - Otherwise set the scan counter to 0 and go to CHECK.
- CHECK: each cycle compares the staged entry with entry `cnt`.
  - Skip `cnt == cfg_idx` and skip inactive entries.
  - Overlap test: `s.base < e.base+e.size && e.base < s.base+s.size`.
  - The first overlap flags an error.
  - Leave CHECK after `cnt == NumRegions-1` and go to RESP.
- RESP: assert `cfg_rsp_valid_o` for one cycle. If there is no error, write the staged entry into the table and, if `cfg_lock_i` was staged, set `locked_q`. Return to IDLE.
- `locked_q` clears only on reset. A write to an already-locked table is rejected and leaves the table unchanged.
- Lookups use the committed table only; staged values are never visible.

## Timing
- Reset values:
  - table = `ResetMap`
  - `locked_q`=0, FSM=IDLE, `cfg_ready_o`=1
  - `cfg_rsp_valid_o`=0, `cfg_rsp_err_o`=0
  - `lkp_valid_o`=0, `lkp_hit_o`=0, `lkp_idx_o`=0
- Config latency, counted from the handshake edge:
  - Rejected (lock or overflow) and inactive writes: response pulse 1 cycle later.
  - Checked writes: response pulse NumRegions+1 cycles later.
- The table updates on the same clock edge that ends RESP.
- A lookup issued in the RESP cycle sees the old table. A lookup issued the cycle after sees the new table.
- Lookup: fixed 1-cycle latency, full throughput with no back-pressure. `lkp_valid_o` is `lkp_valid_i` delayed by one cycle. Outputs hold their previous values when `lkp_valid_o`=0.
- `cfg_valid_i` while not ready is ignored and is not queued.
- Reset asserted mid-CHECK aborts the update. The table returns to `ResetMap` and no response is issued.

## Structure
- Package `carfield_region_map_pkg`:
  - `region_t` {en, base, size}
  - the FSM state enum
  - `region_active()` and `region_overlap()` functions
- Sub-module `carfield_region_lookup`: combinational priority match plus output register, NumRegions-parametrised.

## Test plan
- Reset with the default map; lookup 0x78010000 -> hit=1, idx of the L2 port 0 entry, one cycle later. Lookup 0x70000000 -> hit=0, idx=0.
- Write idx 2, base 0x30000000, size 0x1000 (no overlap) -> `cfg_rsp_valid_o` NumRegions+1 cycles after the handshake, err=0. A lookup of 0x30000800 one cycle after RESP hits idx 2.
- Write idx 3 base 0x78010000, overlapping L2 -> err=1; a lookup of 0x78010000 still returns the original index.
- Write idx 4 base 0xFFFFFFFFFFFFF000, size 0x2000 -> err=1, one cycle later.
- Successful write with `cfg_lock_i`=1 -> `locked_o`=1. The next write gets err=1 after 1 cycle with the table unchanged; after reset, `locked_o`=0.
- Assert `rst_ni` low during CHECK -> no `cfg_rsp_valid_o`, `cfg_ready_o`=1, table equals `ResetMap`.
